// File: rtl/coin_vend_ctrl.sv
// Coin-operated vending controller: accumulates credit, vends one of three items,
// and hands leftover credit to a change dispenser with a valid/ack handshake.
module coin_vend_ctrl #(
    parameter logic [7:0] PRICE1  = 8'd3,
    parameter logic [7:0] PRICE2  = 8'd5,
    parameter logic [7:0] PRICE3  = 8'd8,
    parameter logic [7:0] MAX_BAL = 8'd99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] coin_in,
    input  logic [1:0] select,
    input  logic       cancel,
    input  logic       change_ack,
    output logic [1:0] bought_type,
    output logic [7:0] balance,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       coin_reject,
    output logic       deny
);

    typedef enum logic [1:0] {StIdle, StCredit, StVend, StRefund} state_e;

    state_e     r_state, w_state_d;
    logic [7:0] r_balance, w_balance_d;
    logic [1:0] r_bought, w_bought_d;
    logic       r_cv, w_cv_d;
    logic [7:0] r_ca, w_ca_d;
    logic       r_rej, w_rej_d;
    logic       r_deny, w_deny_d;

    logic [7:0] w_coin_val;
    logic [7:0] w_price;
    logic [8:0] w_sum;
    logic       w_has_coin;
    logic       w_coin_fits;

    always_comb begin
        unique case (coin_in)
            2'b01:   w_coin_val = 8'd1;
            2'b10:   w_coin_val = 8'd5;
            2'b11:   w_coin_val = 8'd10;
            default: w_coin_val = 8'd0;
        endcase
        unique case (select)
            2'b01:   w_price = PRICE1;
            2'b10:   w_price = PRICE2;
            2'b11:   w_price = PRICE3;
            default: w_price = 8'd0;
        endcase
    end

    // Nine-bit sum so the MAX_BAL compare can never be fooled by wraparound.
    assign w_sum       = {1'b0, r_balance} + {1'b0, w_coin_val};
    assign w_coin_fits = (w_sum <= {1'b0, MAX_BAL});
    assign w_has_coin  = (coin_in != 2'b00);

    always_comb begin
        w_state_d   = r_state;
        w_balance_d = r_balance;
        w_bought_d  = 2'b00;
        w_cv_d      = r_cv;
        w_ca_d      = r_ca;
        w_rej_d     = 1'b0;
        w_deny_d    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_has_coin) begin
                    if (w_coin_fits) begin
                        w_balance_d = w_sum[7:0];
                        w_state_d   = StCredit;
                    end else begin
                        w_rej_d = 1'b1;
                    end
                end
            end
            StCredit: begin
                if (cancel) begin
                    w_state_d = StRefund;
                    w_cv_d    = 1'b1;
                    w_ca_d    = r_balance;
                    w_rej_d   = w_has_coin;
                end else if (select != 2'b00 && r_balance >= w_price) begin
                    w_state_d   = StVend;
                    w_balance_d = r_balance - w_price;
                    w_bought_d  = select;
                    w_rej_d     = w_has_coin;
                end else begin
                    // A refused select does not consume the coin in the same cycle.
                    w_deny_d = (select != 2'b00);
                    if (w_has_coin) begin
                        if (w_coin_fits) w_balance_d = w_sum[7:0];
                        else w_rej_d = 1'b1;
                    end
                end
            end
            StVend: begin
                w_rej_d = w_has_coin;
                if (r_balance != 8'd0) begin
                    w_state_d = StRefund;
                    w_cv_d    = 1'b1;
                    w_ca_d    = r_balance;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StRefund: begin
                w_rej_d = w_has_coin;
                if (change_ack) begin
                    w_state_d   = StIdle;
                    w_balance_d = 8'd0;
                    w_cv_d      = 1'b0;
                    w_ca_d      = 8'd0;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_balance <= 8'd0;
            r_bought  <= 2'b00;
            r_cv      <= 1'b0;
            r_ca      <= 8'd0;
            r_rej     <= 1'b0;
            r_deny    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_balance <= w_balance_d;
            r_bought  <= w_bought_d;
            r_cv      <= w_cv_d;
            r_ca      <= w_ca_d;
            r_rej     <= w_rej_d;
            r_deny    <= w_deny_d;
        end
    end

    assign bought_type  = r_bought;
    assign balance      = r_balance;
    assign change_valid = r_cv;
    assign change_amt   = r_ca;
    assign coin_reject  = r_rej;
    assign deny         = r_deny;

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Directed scenarios plus randomized traffic against a credit-level reference model.
module tb_coin_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin_in, select;
    logic       cancel, change_ack;
    logic [1:0] bought_type;
    logic [7:0] balance;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       coin_reject;
    logic       deny;

    int checks   = 0;
    int failures = 0;

    // Reference model: session phase is derived from credit plus two flags.
    int m_bal, m_bought, m_cv, m_ca, m_rej, m_deny;
    bit m_vending, m_refunding;

    always #5 clk = ~clk;

    coin_vend_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .coin_in     (coin_in),
        .select      (select),
        .cancel      (cancel),
        .change_ack  (change_ack),
        .bought_type (bought_type),
        .balance     (balance),
        .change_valid(change_valid),
        .change_amt  (change_amt),
        .coin_reject (coin_reject),
        .deny        (deny)
    );

    function automatic int coin_value(input int c);
        int vals[4] = '{0, 1, 5, 10};
        return vals[c];
    endfunction

    function automatic int item_price(input int s);
        int vals[4] = '{0, 3, 5, 8};
        return vals[s];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_bought"}, 32'(bought_type), 32'(m_bought));
        check({tag, "_balance"}, 32'(balance), 32'(m_bal));
        check({tag, "_cvalid"}, 32'(change_valid), 32'(m_cv));
        check({tag, "_camt"}, 32'(change_amt), 32'(m_ca));
        check({tag, "_reject"}, 32'(coin_reject), 32'(m_rej));
        check({tag, "_deny"}, 32'(deny), 32'(m_deny));
    endtask

    task automatic model_reset();
        m_bal = 0; m_bought = 0; m_cv = 0; m_ca = 0; m_rej = 0; m_deny = 0;
        m_vending = 0; m_refunding = 0;
    endtask

    task automatic model_step(input int c, input int s, input int k, input int a);
        int v = coin_value(c);
        int p = item_price(s);
        m_bought = 0; m_rej = 0; m_deny = 0;
        if (m_refunding) begin
            m_rej = (c != 0);
            if (a != 0) begin
                m_bal = 0; m_cv = 0; m_ca = 0; m_refunding = 0;
            end
        end else if (m_vending) begin
            m_rej = (c != 0);
            m_vending = 0;
            if (m_bal > 0) begin
                m_refunding = 1; m_cv = 1; m_ca = m_bal;
            end
        end else if (m_bal == 0) begin
            if (c != 0) begin
                if (v <= 99) m_bal = v;
                else m_rej = 1;
            end
        end else if (k != 0) begin
            m_refunding = 1; m_cv = 1; m_ca = m_bal; m_rej = (c != 0);
        end else if (s != 0 && m_bal >= p) begin
            m_bal -= p; m_vending = 1; m_bought = s; m_rej = (c != 0);
        end else begin
            m_deny = (s != 0);
            if (c != 0) begin
                if (m_bal + v <= 99) m_bal += v;
                else m_rej = 1;
            end
        end
    endtask

    // Called at posedge+1; inputs are stable across the next edge, outputs sampled 1 after it.
    task automatic cycle(input int c, input int s, input int k, input int a);
        coin_in = 2'(c); select = 2'(s); cancel = 1'(k); change_ack = 1'(a);
        @(posedge clk);
        #1;
        model_step(c, s, k, a);
        check_all("cyc");
        coin_in = 2'b00; select = 2'b00; cancel = 1'b0; change_ack = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; coin_in = 2'b00; select = 2'b00; cancel = 1'b0; change_ack = 1'b0;
        model_reset();
        #2;
        pulse_reset("reset");

        // Coins 5,1,1 then item 1, change 4.
        cycle(2, 0, 0, 0); cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        check("r22_bal7", 32'(balance), 32'd7);
        cycle(0, 1, 0, 0);
        check("r22_bought", 32'(bought_type), 32'd1);
        check("r22_bal4", 32'(balance), 32'd4);
        cycle(0, 0, 0, 0);
        check("r22_bought_clr", 32'(bought_type), 32'd0);
        check("r22_camt", 32'(change_amt), 32'd4);
        cycle(0, 0, 0, 0);
        check("r22_cv_hold", 32'(change_valid), 32'd1);
        cycle(0, 0, 0, 1);
        check("r22_idle_bal", 32'(balance), 32'd0);

        // Insufficient credit, then top-up and buy item 3.
        cycle(2, 0, 0, 0); cycle(0, 3, 0, 0);
        check("r23_deny", 32'(deny), 32'd1);
        check("r23_bal5", 32'(balance), 32'd5);
        cycle(0, 0, 0, 0);
        check("r23_deny_once", 32'(deny), 32'd0);
        cycle(2, 0, 0, 0); cycle(0, 3, 0, 0);
        check("r23_bought", 32'(bought_type), 32'd3);
        cycle(0, 0, 0, 0);
        check("r23_camt", 32'(change_amt), 32'd2);
        cycle(0, 0, 0, 1);

        // Fill to the MAX_BAL limit.
        for (int i = 0; i < 9; i++) cycle(3, 0, 0, 0);
        check("r24_bal90", 32'(balance), 32'd90);
        cycle(3, 0, 0, 0);
        check("r24_reject", 32'(coin_reject), 32'd1);
        check("r24_bal_stay", 32'(balance), 32'd90);
        cycle(0, 0, 1, 0); cycle(0, 0, 0, 1);

        // Cancel wins over a simultaneous coin.
        cycle(3, 0, 0, 0); cycle(2, 0, 1, 0);
        check("r25_reject", 32'(coin_reject), 32'd1);
        check("r25_camt", 32'(change_amt), 32'd10);
        cycle(0, 0, 0, 0);
        check("r25_reject_once", 32'(coin_reject), 32'd0);
        cycle(0, 0, 0, 1);

        // Exact price: no change handshake.
        cycle(2, 0, 0, 0); cycle(0, 2, 0, 0);
        check("r26_bought", 32'(bought_type), 32'd2);
        cycle(0, 0, 0, 0);
        check("r26_no_cv", 32'(change_valid), 32'd0);
        cycle(0, 0, 0, 0);

        // Asynchronous reset during refund.
        cycle(2, 0, 0, 0); cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        check("r27_cv_pre", 32'(change_valid), 32'd1);
        pulse_reset("r27_async");
        cycle(1, 0, 0, 0);
        check("r27_bal1", 32'(balance), 32'd1);
        cycle(0, 0, 1, 0); cycle(0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                int c = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                int s = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
                int k = ($urandom_range(0, 11) == 0) ? 1 : 0;
                int a = ($urandom_range(0, 2) == 0) ? 1 : 0;
                cycle(c, s, k, a);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
